prim_sync_debounce: RTL and testbench
=====================================

PRIM_SYNC_DEBOUNCE -- requirements
Module: prim_sync_debounce

Interface
REQ-001 Parameter Width, default 4: number of independent input bits.
REQ-002 Parameter CntWidth, default 16: width of the per-bit debounce counter and of limit_i.
REQ-003 Parameter ResetValue, default 0: value of the synchronizer flops and q_o for every bit after reset.
REQ-004 clk_i  input  1  receive clock.
REQ-005 rst_ni  input  1  reset; asynchronous assert, active-low, synchronous deassert provided externally.
REQ-006 d_i  input  Width  raw asynchronous inputs (board buttons, switches, strobes).
REQ-007 en_i  input  1  debounce enable; 0 forces all bits idle.
REQ-008 limit_i  input  CntWidth  required stable cycles L; quasi-static.
REQ-009 q_o  output  Width  debounced, registered level per bit.
REQ-010 rise_o  output  Width  one-cycle pulse per bit on a committed 0->1 transition of q_o.
REQ-011 fall_o  output  Width  one-cycle pulse per bit on a committed 1->0 transition of q_o.
REQ-012 busy_o  output  1  registered OR of all bits in WAIT.

Function
REQ-013 d_i shall pass through the team's generic two-flop double synchronizer (Width, ResetValue) before any other logic; its output is s.
REQ-014 Each bit shall own a two-state FSM {STABLE, WAIT} and a CntWidth counter cnt; bits are fully independent.
REQ-015 Effective limit Leff = 1 when limit_i == 0, else limit_i.
REQ-016 STABLE, s == q_o: stay STABLE, cnt = 0.
REQ-017 STABLE, s != q_o: go WAIT, cnt = 1; when Leff == 1, commit instead (REQ-019) and stay STABLE.
REQ-018 WAIT, s == q_o: return STABLE, cnt = 0, q_o unchanged, no pulse (glitch rejected).
REQ-019 WAIT, s != q_o, cnt + 1 >= Leff: commit -- q_o <= s, corresponding rise_o or fall_o = 1 for exactly the next cycle, go STABLE, cnt = 0.
REQ-020 WAIT, s != q_o, cnt + 1 < Leff: cnt <= cnt + 1; cnt shall never wrap.
REQ-021 Latency: d_i stable change sampled at edge e0 -> q_o and pulse update at edge e0 + Leff + 1; rise_o/fall_o high for that single cycle.
REQ-022 s pulses shorter than Leff consecutive cycles shall never reach q_o.
REQ-023 limit_i lowered mid-WAIT: the >= compare commits at the next edge with s != q_o; raised: counting continues to the new value.
REQ-024 en_i = 0: all bits forced STABLE, cnt = 0, q_o held, rise_o = fall_o = 0, busy_o = 0; the synchronizer keeps running.
REQ-025 en_i re-asserted: evaluation restarts from STABLE against held q_o.
REQ-026 rise_o[i] and fall_o[i] shall never be high in the same cycle; several bits may pulse in the same cycle.
REQ-027 busy_o shall be 1 in every cycle in which at least one bit is in WAIT.

Reset
REQ-028 rst_ni low shall immediately set synchronizer flops and q_o to ResetValue, rise_o = fall_o = 0, busy_o = 0, all FSMs STABLE, cnt = 0.
REQ-029 Reset mid-WAIT shall abort with no pulse; after release, a bit whose s != ResetValue starts a fresh full Leff count.

Verification
REQ-030 L=4, ResetValue=0, d_i[0] 0->1 held, sampled at e0 -> q_o[0] = 1 and rise_o[0] = 1 for one cycle after e5; busy_o high during e2..e5.
REQ-031 L=4, d_i[1] high for 3 cycles then low -> q_o[1] stays 0, no rise_o/fall_o, busy_o returns to 0.
REQ-032 limit_i=0, d_i[2] toggled 1 then 0 with 5-cycle spacing -> each edge commits 2 edges after sampling, rise_o[2] then fall_o[2], one cycle each.
REQ-033 L=8, d_i = 4'b1111 held, en_i dropped after 5 cycles for 3 cycles then raised -> no commit while disabled; q_o = 4'b1111 with rise_o = 4'b1111 exactly 8 edges after re-enable.
REQ-034 L=6, d_i[3] high, rst_ni pulsed low at count 4 -> q_o = 0 immediately, no pulse; rise_o[3] after 2 sync edges + 6 edges following release.
REQ-035 L=10 mid-WAIT at cnt 5, limit_i changed to 3 -> commit at the next edge with s != q_o, single pulse.

Source files
------------

// File: rtl/prim_sync_debounce.sv
`default_nettype none
// ============================================================================
// prim_sync_debounce : two-flop synchronizer + per-bit stable-count debouncer
// Revision: 1.0
// ============================================================================

module prim_flop_2sync #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_sync1;
    logic [Width-1:0] r_sync2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= ResetValue;
            r_sync2 <= ResetValue;
        end else begin
            r_sync1 <= d_i;
            r_sync2 <= r_sync1;
        end
    end

    assign q_o = r_sync2;

endmodule

module prim_sync_debounce #(
    parameter int               Width      = 4,
    parameter int               CntWidth   = 16,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    d_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] limit_i,
    output logic [Width-1:0]    q_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    output logic                busy_o
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_e;

    logic [Width-1:0]    w_s;
    logic [Width-1:0]    w_wait_nxt;
    logic [CntWidth-1:0] w_limit_eff;
    logic                r_busy;

    prim_flop_2sync #(
        .Width      (Width),
        .ResetValue (ResetValue)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (d_i),
        .q_o    (w_s)
    );

    // A zero limit behaves as a single-cycle requirement.
    assign w_limit_eff = (limit_i == '0) ? {{(CntWidth-1){1'b0}}, 1'b1} : limit_i;

    for (genvar i = 0; i < Width; i++) begin : g_bit
        state_e              r_state;
        logic [CntWidth-1:0] r_cnt;
        logic                r_q;
        logic                r_rise;
        logic                r_fall;
        logic [CntWidth-1:0] w_cnt_base;
        logic [CntWidth:0]   w_cnt_inc;
        logic                w_mismatch;
        logic                w_commit;

        // One extra bit on the increment keeps the compare exact and wrap-free.
        assign w_cnt_base = (r_state == ST_WAIT) ? r_cnt : '0;
        assign w_cnt_inc  = {1'b0, w_cnt_base} + {{CntWidth{1'b0}}, 1'b1};
        assign w_mismatch = w_s[i] ^ r_q;
        assign w_commit   = w_mismatch && (w_cnt_inc >= {1'b0, w_limit_eff});

        assign w_wait_nxt[i] = en_i && w_mismatch && !w_commit;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_q     <= ResetValue[i];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (!en_i || !w_mismatch) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end else if (w_commit) begin
                    r_q     <= w_s[i];
                    r_rise  <= w_s[i];
                    r_fall  <= ~w_s[i];
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= ST_WAIT;
                    r_cnt   <= w_cnt_inc[CntWidth-1:0];
                end
            end
        end

        assign q_o[i]    = r_q;
        assign rise_o[i] = r_rise;
        assign fall_o[i] = r_fall;
    end

    // Built from next-state so busy lines up with the cycles a bit sits in WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_wait_nxt;
        end
    end

    assign busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prim_sync_debounce.sv
`default_nettype none
// ============================================================================
// tb_prim_sync_debounce : directed + randomized check against a run-length model
// Revision: 1.0
// ============================================================================
module tb_prim_sync_debounce;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk;
    logic          rst_ni;
    logic [W-1:0]  d_i;
    logic          en_i;
    logic [CW-1:0] limit_i;
    logic [W-1:0]  q_o;
    logic [W-1:0]  rise_o;
    logic [W-1:0]  fall_o;
    logic          busy_o;

    prim_sync_debounce #(
        .Width      (W),
        .CntWidth   (CW),
        .ResetValue (4'b0000)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .d_i     (d_i),
        .en_i    (en_i),
        .limit_i (limit_i),
        .q_o     (q_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]  cur_d;
    logic          cur_en;
    logic [CW-1:0] cur_lim;

    // Reference: per bit, count consecutive enabled edges where the synced input
    // differs from the output level; commit once that run reaches the limit.
    logic [W-1:0] m_s1, m_s, m_q, m_rise, m_fall;
    logic         m_busy;
    int           m_run [W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s = '0; m_q = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        int leff;
        leff   = (cur_lim == 0) ? 1 : int'(cur_lim);
        m_rise = '0;
        m_fall = '0;
        m_busy = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!cur_en || m_s[i] == m_q[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] + 1 >= leff) begin
                m_q[i] = m_s[i];
                if (m_s[i]) m_rise[i] = 1'b1;
                else        m_fall[i] = 1'b1;
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
            end
            if (m_run[i] > 0) m_busy = 1'b1;
        end
        m_s  = m_s1;
        m_s1 = cur_d;
    endtask

    task automatic compare_all();
        check("q", 32'(q_o), 32'(m_q));
        check("rise", 32'(rise_o), 32'(m_rise));
        check("fall", 32'(fall_o), 32'(m_fall));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("excl", 32'(rise_o & fall_o), 32'd0);
    endtask

    // Called just after a rising edge; drives, waits one edge, then compares.
    task automatic tick();
        d_i     = cur_d;
        en_i    = cur_en;
        limit_i = cur_lim;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
    endtask

    task automatic wait_pulse(input logic [W-1:0] mask, input bit use_fall, output int n);
        logic [W-1:0] seen;
        n = 0;
        do begin
            tick();
            n++;
            seen = use_fall ? fall_o : rise_o;
        end while (((seen & mask) != mask) && n < 40);
    endtask

    task automatic settle_low();
        cur_lim = 1;
        cur_d   = '0;
        repeat (4) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic acc;
        rst_ni  = 1'b0;
        cur_d   = '0;
        cur_en  = 1'b1;
        cur_lim = 16'd4;
        d_i     = '0;
        en_i    = 1'b1;
        limit_i = 16'd4;
        model_reset();
        #1;
        compare_all();
        check("rst_q", 32'(q_o), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;

        // L=4 single bit rise: visible L+1 edges after the sampling edge
        cur_d = 4'b0001;
        wait_pulse(4'b0001, 1'b0, n);
        check("lat_l4", 32'(n), 32'd6);
        check("q0_l4", 32'(q_o[0]), 32'd1);
        repeat (3) tick();

        // 3-cycle glitch on bit 1 is rejected
        acc   = 1'b0;
        cur_d = 4'b0011;
        repeat (3) tick();
        cur_d = 4'b0001;
        repeat (8) begin
            tick();
            acc = acc | rise_o[1] | fall_o[1];
        end
        check("glitch_pulse", 32'(acc), 32'd0);
        check("glitch_q", 32'(q_o[1]), 32'd0);
        check("glitch_busy", 32'(busy_o), 32'd0);

        // limit 0 acts as 1: two edges after sampling
        cur_lim = 16'd0;
        cur_d   = 4'b0101;
        wait_pulse(4'b0100, 1'b0, n);
        check("lat_l0_rise", 32'(n), 32'd3);
        repeat (2) tick();
        cur_d = 4'b0001;
        wait_pulse(4'b0100, 1'b1, n);
        check("lat_l0_fall", 32'(n), 32'd3);

        // enable drop restarts the count
        settle_low();
        check("settle_q", 32'(q_o), 32'd0);
        cur_lim = 16'd8;
        cur_d   = 4'b1111;
        repeat (5) tick();
        cur_en = 1'b0;
        repeat (3) tick();
        check("dis_hold_q", 32'(q_o), 32'd0);
        check("dis_busy", 32'(busy_o), 32'd0);
        cur_en = 1'b1;
        wait_pulse(4'b1111, 1'b0, n);
        check("reen_lat", 32'(n), 32'd8);
        check("reen_q", 32'(q_o), 32'hF);

        // reset mid-WAIT aborts, then a fresh full count
        settle_low();
        cur_lim = 16'd6;
        cur_d   = 4'b1000;
        repeat (6) tick();
        check("midwait_busy", 32'(busy_o), 32'd1);
        do_reset();
        wait_pulse(4'b1000, 1'b0, n);
        check("post_rst_lat", 32'(n), 32'd8);

        // lowering the limit mid-WAIT commits on the next edge
        settle_low();
        cur_lim = 16'd10;
        cur_d   = 4'b0001;
        repeat (7) tick();
        check("pre_lower_q", 32'(q_o[0]), 32'd0);
        cur_lim = 16'd3;
        tick();
        check("lower_rise", 32'(rise_o[0]), 32'd1);
        tick();
        check("lower_single", 32'(rise_o[0]), 32'd0);

        // randomized phase
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 7) == 0) cur_d = cur_d ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) cur_lim = 16'($urandom_range(0, 6));
            if (cur_en && $urandom_range(0, 59) == 0) cur_en = 1'b0;
            else if (!cur_en && $urandom_range(0, 4) == 0) cur_en = 1'b1;
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
